// File: rtl/la_sample_capture_if.sv
// Firmware-facing port bundle of the logic-analyzer capture stage:
// configuration writes, the read strobe, the ex_data word and the done pulse.
interface la_sample_capture_if;
  logic        cfg_we;
  logic        cfg_addr;
  logic [31:0] cfg_wdata;
  logic        rd_req;
  logic [31:0] ex_data;
  logic        irq_done;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, rd_req,
    input  ex_data, irq_done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, rd_req,
    output ex_data, irq_done
  );
endinterface

// File: rtl/la_sample_capture.sv
// Logic-analyzer capture stage: synchronised probe bus, masked-value trigger,
// fixed-length capture into a RAM and a one-word-per-strobe drain into ex_data.
module la_sample_capture #(
  parameter int DEPTH_LOG2 = 8,
  parameter int PROBE_W    = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [PROBE_W-1:0] probe_in,
  la_sample_capture_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t                state, state_next;
  logic [PROBE_W-1:0]    sync1, ps;
  logic [15:0]           post_len;
  logic [PROBE_W-1:0]    trig_mask, trig_val;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_addr;
  logic [CW-1:0]         count, len;
  logic [12:0]           remaining;
  logic [15:0]           mem [DEPTH];
  logic [15:0]           ram_q, head;
  logic                  valid, pend, irq_q;
  logic                  cfg_ctrl, do_clr, do_arm, restart;
  logic                  hit, do_write, going_done, accept, fetch;

  assign cfg_ctrl = bus.cfg_we && !bus.cfg_addr;
  assign do_clr   = cfg_ctrl && bus.cfg_wdata[1];
  // Arm is only meaningful from IDLE or DONE; clear in the same write wins.
  assign do_arm   = cfg_ctrl && bus.cfg_wdata[0] && !bus.cfg_wdata[1]
                    && (state == IDLE || state == DONE);
  assign restart  = do_clr || do_arm;

  assign hit = ((ps ^ trig_val) & trig_mask) == '0;

  always_comb begin
    if (post_len == 16'd0 || 32'(post_len) >= DEPTH) len = CW'(DEPTH);
    else                                             len = CW'(post_len);
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    going_done = 1'b0;
    unique case (state)
      IDLE:    if (do_arm) state_next = ARMED;
      ARMED,
      CAPTURE: begin
        if (state == CAPTURE || hit) begin
          do_write   = 1'b1;
          state_next = CAPTURE;
          if (count + 1'b1 == len) begin
            state_next = DONE;
            going_done = 1'b1;
          end
        end
      end
      DONE:    if (do_arm) state_next = ARMED;
      default: state_next = IDLE;
    endcase
    if (do_clr) begin
      state_next = IDLE;
      do_write   = 1'b0;
      going_done = 1'b0;
    end
  end

  // irq_q is high exactly in the first DONE cycle, which launches the prefetch.
  // A pop reads the following word straight away so it is presented two cycles later.
  assign accept  = (state == DONE) && valid && bus.rd_req;
  assign fetch   = !restart && (irq_q || (accept && remaining > 13'd1));
  assign rd_addr = accept ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1     <= '0;
      ps        <= '0;
      state     <= IDLE;
      irq_q     <= 1'b0;
      post_len  <= '0;
      trig_mask <= '0;
      trig_val  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      valid     <= 1'b0;
      pend      <= 1'b0;
      head      <= '0;
    end else begin
      sync1 <= probe_in;
      ps    <= sync1;
      state <= state_next;
      irq_q <= going_done;

      if (bus.cfg_we) begin
        if (!bus.cfg_addr) begin
          post_len <= bus.cfg_wdata[31:16];
        end else begin
          trig_mask <= bus.cfg_wdata[16 +: PROBE_W];
          trig_val  <= bus.cfg_wdata[0 +: PROBE_W];
        end
      end

      if (restart) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        remaining <= '0;
        valid     <= 1'b0;
        pend      <= 1'b0;
        head      <= '0;
      end else begin
        if (do_write) begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
        end
        if (going_done) remaining <= 13'(len);
        pend <= fetch;
        if (pend) begin
          head  <= ram_q;
          valid <= 1'b1;
        end
        if (accept) begin
          valid     <= 1'b0;
          rd_ptr    <= rd_ptr + 1'b1;
          remaining <= remaining - 1'b1;
        end
      end
    end
  end

  // NOTE: the RAM and its read register have no reset; valid hides stale contents.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= 16'(ps);
    if (fetch)    ram_q       <= mem[rd_addr];
  end

  assign bus.ex_data  = {valid, state == DONE, state == ARMED || state == CAPTURE,
                         remaining, valid ? head : 16'h0000};
  assign bus.irq_done = irq_q;
endmodule

// File: tb/tb_la_sample_capture.sv
// Self-checking bench for la_sample_capture: a queue of expected samples is filled
// as the probe is driven and emptied as firmware-style reads drain the buffer.
module tb_la_sample_capture;
  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] probe_in;

  la_sample_capture_if bus ();

  la_sample_capture #(.DEPTH_LOG2(8), .PROBE_W(16)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .probe_in (probe_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] q[$];
  logic [15:0] ramp;
  bit          ramp_on = 1'b0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    if (ramp_on) begin
      probe_in = ramp;
      ramp     = ramp + 16'd1;
    end
    cyc();
  endtask

  task automatic cfg_write(input logic addr, input logic [31:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = d;
    step();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic check_word(input string name, input logic [31:0] exp);
    n_vec++;
    if (bus.ex_data !== exp) begin
      n_err++;
      $display("FAIL %s: ex_data got %h expected %h", name, bus.ex_data, exp);
    end
  endtask

  // Ramp so that the synchronised sample seen in the trigger cycle is `base`;
  // returns in that trigger cycle with n expected samples queued.
  task automatic arm_ramp(input logic [15:0] base, input logic [15:0] plen, input int n);
    ramp_on  = 1'b1;
    probe_in = base - 16'd1;
    cyc();
    probe_in = base;
    cyc();
    ramp = base + 16'd1;
    cfg_write(1'b0, {plen, 16'h0001});
    for (int j = 0; j < n; j++) q.push_back(base + 16'(j));
  endtask

  // Waits for irq_done; with exact set, it must arrive n cycles after the trigger.
  task automatic wait_done(input string name, input int n, input bit exact, input int start_k);
    int k;
    bit seen;
    k    = start_k;
    seen = 1'b0;
    while (!seen && k < n + 40) begin
      step();
      k++;
      if (bus.irq_done === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen || (exact && k != n)) begin
      n_err++;
      $display("FAIL %s irq_latency: got %0d (seen=%0b) expected %0d", name, k - start_k, seen, n - start_k);
    end
    check_word({name, " done_entry"}, {3'b010, 13'(q.size()), 16'h0000});
    step();
    n_vec++;
    if (bus.irq_done !== 1'b0 || bus.ex_data[31] !== 1'b0) begin
      n_err++;
      $display("FAIL %s irq_single/prefetch: irq %b valid %b expected 0 0", name, bus.irq_done, bus.ex_data[31]);
    end
    step();
    n_vec++;
    if (bus.ex_data[31] !== 1'b1) begin
      n_err++;
      $display("FAIL %s prefetch_valid: valid %b expected 1", name, bus.ex_data[31]);
    end
  endtask

  task automatic drain(input string name);
    int guard;
    logic [31:0] exp;
    guard = 0;
    while (bus.ex_data[31] !== 1'b1 && guard < 8) begin
      cyc();
      guard++;
    end
    while (q.size() > 0) begin
      exp = {3'b110, 13'(q.size()), q[0]};
      check_word({name, " read"}, exp);
      void'(q.pop_front());
      bus.rd_req = 1'b1;
      cyc();
      bus.rd_req = 1'b0;
      n_vec++;
      if (bus.ex_data[31] !== 1'b0) begin
        n_err++;
        $display("FAIL %s pop_gap: valid %b expected 0", name, bus.ex_data[31]);
      end
      cyc();
    end
    check_word({name, " drained"}, 32'h4000_0000);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) cyc();
    check_word("reset ex_data", 32'h0);
    n_vec++;
    if (bus.irq_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset irq_done: got %b expected 0", bus.irq_done);
    end
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_immediate();
    cfg_write(1'b1, 32'h0);
    arm_ramp(16'h0010, 16'd4, 4);
    wait_done("immediate", 4, 1'b1, 0);
    drain("immediate");
    bus.rd_req = 1'b1;
    cyc();
    bus.rd_req = 1'b0;
    cyc();
    check_word("immediate extra_pop", 32'h4000_0000);
  endtask

  task automatic test_masked();
    ramp_on  = 1'b0;
    probe_in = 16'h1200;
    cfg_write(1'b1, 32'h00FF_005A);
    repeat (3) cyc();
    cfg_write(1'b0, 32'h0002_0001);
    repeat (4) cyc();
    check_word("masked armed_wait", 32'h2000_0000);
    probe_in = 16'h345A;
    q.push_back(16'h345A);
    cyc();
    probe_in = 16'h7700;
    q.push_back(16'h7700);
    wait_done("masked", 2, 1'b0, 0);
    drain("masked");
  endtask

  task automatic test_full_depth();
    cfg_write(1'b1, 32'h0);
    arm_ramp(16'hA000, 16'd0, 256);
    wait_done("full", 256, 1'b1, 0);
    drain("full");
    arm_ramp(16'hFFFE, 16'd4, 4);
    wait_done("rearm", 4, 1'b1, 0);
    drain("rearm");
  endtask

  task automatic test_clear_mid_capture();
    int irq_cnt;
    irq_cnt = 0;
    arm_ramp(16'h0200, 16'd100, 100);
    repeat (9) step();
    cfg_write(1'b0, 32'h0064_0002);
    q.delete();
    check_word("clear ex_data", 32'h0);
    repeat (120) begin
      step();
      if (bus.irq_done === 1'b1) irq_cnt++;
    end
    n_vec++;
    if (irq_cnt != 0) begin
      n_err++;
      $display("FAIL clear irq_count: got %0d expected 0", irq_cnt);
    end
    check_word("clear stays_idle", 32'h0);
    arm_ramp(16'h0300, 16'd3, 3);
    wait_done("after_clear", 3, 1'b1, 0);
    drain("after_clear");
  endtask

  task automatic test_arm_clear_same_write();
    ramp_on  = 1'b0;
    probe_in = 16'h0000;
    cfg_write(1'b1, 32'hFFFF_BEEF);
    repeat (3) cyc();
    cfg_write(1'b0, 32'h0000_0001);
    check_word("armclr armed", 32'h2000_0000);
    bus.rd_req = 1'b1;
    cyc();
    bus.rd_req = 1'b0;
    cyc();
    check_word("armclr rd_ignored", 32'h2000_0000);
    cfg_write(1'b0, 32'h0000_0003);
    check_word("armclr idle", 32'h0);
  endtask

  task automatic test_arm_during_capture();
    cfg_write(1'b1, 32'h0);
    arm_ramp(16'h0500, 16'd8, 8);
    repeat (2) step();
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 1'b0;
    bus.cfg_wdata = 32'h0008_0001;
    step();
    bus.cfg_we    = 1'b0;
    wait_done("arm_in_capture", 8, 1'b1, 3);
    drain("arm_in_capture");
  endtask

  task automatic test_reset_mid_capture();
    cfg_write(1'b1, 32'h0);
    arm_ramp(16'h0700, 16'd100, 100);
    repeat (5) step();
    resetn = 1'b0;
    repeat (3) step();
    check_word("reset_mid ex_data", 32'h0);
    n_vec++;
    if (bus.irq_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid irq_done: got %b expected 0", bus.irq_done);
    end
    resetn = 1'b1;
    q.delete();
    repeat (3) step();
    check_word("reset_mid idle", 32'h0);
  endtask

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = 1'b0;
    bus.cfg_wdata = 32'h0;
    bus.rd_req    = 1'b0;
    probe_in      = 16'h0;
    resetn        = 1'b0;
    test_reset();
    test_immediate();
    test_masked();
    test_full_depth();
    test_clear_mid_capture();
    test_arm_clear_same_write();
    test_arm_during_capture();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
